// File: rtl/circ_shift_reg_16bits_block.sv
// WIDTH-bit circular shift register: parallel load, otherwise rotate left each clock.
// The MSB is the serial output; q exposes the whole register.
module circ_shift_reg_16bits_block #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_in,
  input  logic             load,
  output logic             shift_out,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_next;

  // Next state: a load wins over rotation; the MSB wraps into bit 0.
  always_comb begin
    w_next = r_shift;
    if (load) begin
      w_next = load_in;
    end else begin
      w_next = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
    end
  end

  // State register, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= {WIDTH{1'b0}};
    end else begin
      r_shift <= w_next;
    end
  end

  assign q         = r_shift;
  assign shift_out = r_shift[WIDTH-1];

endmodule

// File: tb/tb_circ_shift_reg_16bits_block.sv
// Self-checking bench for circ_shift_reg_16bits_block: directed scenarios plus random traffic,
// checked against a model that tracks the last loaded value and the number of rotations since.
module tb_circ_shift_reg_16bits_block;

  logic        clock;
  logic        reset_n;
  logic [15:0] load_in;
  logic        load;
  logic        shift_out;
  logic [15:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: value last loaded and how many rotations have happened since.
  logic [15:0] m_val;
  int          m_k;

  circ_shift_reg_16bits_block #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_in   (load_in),
    .load      (load),
    .shift_out (shift_out),
    .q         (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
    logic [31:0] d;
    int s;
    s = k % 16;
    d = {v, v};
    return d[31 - s -: 16];
  endfunction

  function automatic logic exp_sout(input logic [15:0] v, input int k);
    return v[15 - (k % 16)];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"}, q, rotl(m_val, m_k));
    check({tag, "_sout"}, {15'd0, shift_out}, {15'd0, exp_sout(m_val, m_k)});
  endtask

  // One clock edge with the given load controls, then update model and compare.
  task automatic step(input logic ld, input logic [15:0] val, input string tag);
    @(negedge clock);
    load    = ld;
    load_in = val;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      m_val = 16'h0000;
      m_k   = 0;
    end else if (ld) begin
      m_val = val;
      m_k   = 0;
    end else begin
      m_k = m_k + 1;
    end
    check_model(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    load_in = 16'h0000;
    m_val   = 16'h0000;
    m_k     = 0;
    #12;
    check("reset_q", q, 16'h0000);
    check("reset_sout", {15'd0, shift_out}, 16'h0000);

    // Release reset between edges; first edge loads E000.
    @(negedge clock);
    reset_n = 1'b1;
    step(1'b1, 16'hE000, "load_e000");
    check("e000_loaded", q, 16'hE000);
    for (int i = 1; i <= 64; i++) begin
      step(1'b0, 16'($urandom), "pulse_gap");
      check("pulse_gap_bit", {15'd0, shift_out},
            {15'd0, (((i % 16) < 3) ? 1'b1 : 1'b0)});
      if (i % 16 == 0) check("e000_period", q, 16'hE000);
    end

    // Wrap of both end bits.
    step(1'b1, 16'h8001, "load_8001");
    step(1'b0, 16'h5555, "rot_8001");
    check("wrap_0003", q, 16'h0003);
    for (int i = 0; i < 15; i++) step(1'b0, 16'($urandom), "rot_8001");
    check("wrap_8001", q, 16'h8001);

    // Five rotations of A5C3 with popcount held at 8.
    step(1'b1, 16'hA5C3, "load_a5c3");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 16'($urandom), "rot_a5c3");
      check("popcount", 16'($countones(q)), 16'd8);
    end
    check("a5c3_rot5", q, 16'hB874);

    // Load held high over two edges: last value wins.
    step(1'b1, 16'h1234, "hold_1234");
    step(1'b1, 16'hFFFF, "hold_ffff");
    check("hold_last", q, 16'hFFFF);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 16'($urandom), "rot_ffff");
      check("ffff_sout", {15'd0, shift_out}, 16'h0001);
    end

    // Reset mid-rotation, between edges.
    step(1'b1, 16'hE000, "load_e000b");
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, "rot_e000b");
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_clr_q", q, 16'h0000);
    check("async_clr_sout", {15'd0, shift_out}, 16'h0000);
    step(1'b1, 16'hBEEF, "in_reset_load");
    step(1'b0, 16'h1111, "in_reset_rot");
    check("in_reset_q", q, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 16'($urandom), "post_reset_rot");
    check("post_reset_zero", q, 16'h0000);
    step(1'b1, 16'h00C0, "post_reset_load");
    check("post_reset_loaded", q, 16'h00C0);

    // All-zero pattern stays zero.
    step(1'b1, 16'h0000, "load_zero");
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 16'($urandom), "rot_zero");
      check("zero_q", q, 16'h0000);
    end

    // Random load/rotate mix.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0, 16'($urandom), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/circ_shift_reg_16bits_block.md
CIRC_SHIFT_REG_16BITS_BLOCK -- requirements
Module: circ_shift_reg_16bits

Interface
REQ-001 Parameter: WIDTH, default 16, register length in bits; the block SHALL be verified at 16 only.
REQ-002 Port: clock  input  1  rising-edge clock for all sequential logic.
REQ-003 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: load_in  input  WIDTH  parallel load value.
REQ-005 Port: load  input  1  synchronous parallel-load request, active-high.
REQ-006 Port: shift_out  output  1  serial output, equal to register bit [WIDTH-1] (MSB).
REQ-007 Port: q  output  WIDTH  parallel view of the current register contents.

Function
REQ-008 The block SHALL hold one WIDTH-bit state register R; q SHALL equal R combinationally.
REQ-009 shift_out SHALL equal R[WIDTH-1] combinationally, with no added register stage.
REQ-010 On a rising clock edge with load=1, R SHALL take load_in; no rotation occurs that cycle.
REQ-011 On a rising clock edge with load=0, R SHALL rotate left by one: R <= {R[WIDTH-2:0], R[WIDTH-1]}.
REQ-012 Rotation SHALL wrap: the bit leaving position WIDTH-1 SHALL enter position 0 in the same edge; no bit is lost or inserted.
REQ-013 After a load of value V, shift_out SHALL present V[15], V[14], ..., V[0] on successive cycles, then repeat with period WIDTH (16 cycles) indefinitely while load=0.
REQ-014 load held high for several edges SHALL reload load_in on every such edge; the last loaded value is the starting point once load falls.
REQ-015 A change of load_in while load=0 SHALL have no effect on R.
REQ-016 The population count of R SHALL be invariant under rotation.

Reset
REQ-017 Assertion of reset_n=0 SHALL clear R to all zeros immediately, independent of clock, so that q=0 and shift_out=0.
REQ-018 While reset_n=0, load and clock edges SHALL be ignored and R SHALL remain zero.
REQ-019 On deassertion of reset_n, the first rising edge with reset_n=1 SHALL apply the normal load/rotate rule.
REQ-020 Reset asserted mid-sequence SHALL discard the pattern; a new load is required to restart output.

Verification
REQ-021 Reset then load 16'hE000 for one edge, then load=0 for 64 cycles -> shift_out = 1,1,1 followed by 13 zeros, repeating every 16 cycles (3-over-13 pulse/gap pattern); q returns to 16'hE000 every 16 cycles.
REQ-022 Load 16'h8001, rotate one edge -> q=16'h0003; rotate 15 more edges -> q=16'h8001 (wrap verified).
REQ-023 Load 16'hA5C3 then rotate 5 edges -> q=16'hB874; population count stays 8 at every cycle.
REQ-024 Hold load=1 with load_in changing 16'h1234 -> 16'hFFFF across two edges -> q=16'hFFFF and shift_out=1 on every subsequent rotation.
REQ-025 Mid-rotation of 16'hE000, drive reset_n=0 between clock edges -> q=0 and shift_out=0 immediately, staying 0 through clock edges until a new load after release.
REQ-026 Load 16'h0000 and rotate 20 edges -> shift_out=0 and q=0 throughout.
